// File: rtl/recorder_pkg.sv
// Shared types and default sizing for the sequence recorder.
package recorder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECORD = 2'd1,
        FILL   = 2'd2
    } state_t;

    localparam int unsigned DEF_NOTES       = 10;
    localparam int unsigned DEF_ADDR_W      = 6;
    localparam int unsigned DEF_STEP_CYCLES = 6250000;
    localparam int unsigned DEPTH           = 2 ** DEF_ADDR_W;

endpackage

// File: rtl/sequence_recorder_if.sv
// Note sequence RAM write port shared between the recorder and the RAM.
interface sequence_recorder_if
    import recorder_pkg::*;
#(
    parameter int unsigned NOTES  = DEF_NOTES,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) ();

    logic [ADDR_W-1:0] ram_address;
    logic [NOTES-1:0]  ram_data;
    logic              ram_wren;

    modport master (output ram_address, output ram_data, output ram_wren);
    modport slave  (input  ram_address, input  ram_data, input  ram_wren);

endinterface

// File: rtl/sequence_recorder_key_sync.sv
// Two-flop synchroniser for the raw asynchronous key levels.
module key_sync
    import recorder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_NOTES
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sequence_recorder.sv
// Quantised key-press recorder writing one RAM word per step, zero-filling after an early stop.
// Optional metronome output click when RECORDER_METRONOME_EN is defined.
module sequence_recorder
    import recorder_pkg::*;
#(
    parameter int unsigned STEP_CYCLES = DEF_STEP_CYCLES,
    parameter int unsigned NOTES       = DEF_NOTES,
    parameter int unsigned ADDR_W      = DEF_ADDR_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               record_start,
    input  logic               record_stop,
    input  logic [NOTES-1:0]   keys,
`ifdef RECORDER_METRONOME_EN
    output logic               click,
`endif
    output logic               recording,
    output logic               done,
    sequence_recorder_if.master ram
);

    localparam int unsigned     CNT_W     = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(STEP_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'((2 ** ADDR_W) - 1);

    logic [NOTES-1:0]  keys_s;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NOTES-1:0]  acc_q, acc_d;
    logic [NOTES-1:0]  seen;
    logic              wr_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [NOTES-1:0]  wr_data_d;
    logic              recording_d;
    logic              done_d;

    key_sync #(.WIDTH(NOTES)) u_key_sync (
        .clock (clock),
        .reset (reset),
        .d     (keys),
        .q     (keys_s)
    );

    // Next state, datapath and registered-output values.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        wr_d      = 1'b0;
        wr_addr_d = '0;
        wr_data_d = '0;
        seen      = acc_q | keys_s;

        case (state_q)
            IDLE: begin
                if (record_start && !record_stop) begin
                    state_d = RECORD;
                    addr_d  = '0;
                    cnt_d   = CNT_LOAD;
                    acc_d   = '0;
                end
            end
            RECORD: begin
                if (record_stop || cnt_q == '0) begin
                    wr_d      = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = seen;
                    acc_d     = '0;
                    cnt_d     = CNT_LOAD;
                    if (addr_q == LAST_ADDR) begin
                        state_d = IDLE;
                    end else begin
                        addr_d = addr_q + 1'b1;
                        if (record_stop) state_d = FILL;
                    end
                end else begin
                    acc_d = seen;
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FILL: begin
                wr_d      = 1'b1;
                wr_addr_d = addr_q;
                if (addr_q == LAST_ADDR) state_d = IDLE;
                else                     addr_d  = addr_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase

        recording_d = (state_d == RECORD);
        // Every take ends with a write to the last address, so done follows that write.
        done_d      = ram.ram_wren && (ram.ram_address == LAST_ADDR);
    end

`ifdef RECORDER_METRONOME_EN
    localparam logic [CNT_W-1:0] CLICK_MIN = CNT_W'(STEP_CYCLES - STEP_CYCLES / 4);
    logic click_d;

    always_comb begin
        click_d = (state_d == RECORD) && (addr_d[1:0] == 2'b00) && (cnt_d >= CLICK_MIN);
    end

    always_ff @(posedge clock) begin
        if (reset) click <= 1'b0;
        else       click <= click_d;
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            cnt_q           <= '0;
            acc_q           <= '0;
            ram.ram_wren    <= 1'b0;
            ram.ram_address <= '0;
            ram.ram_data    <= '0;
            recording       <= 1'b0;
            done            <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            cnt_q           <= cnt_d;
            acc_q           <= acc_d;
            ram.ram_wren    <= wr_d;
            ram.ram_address <= wr_addr_d;
            ram.ram_data    <= wr_data_d;
            recording       <= recording_d;
            done            <= done_d;
        end
    end

endmodule

// File: tb/tb_sequence_recorder.sv
// Randomised bench for sequence_recorder against a step-window reference model.
module tb_sequence_recorder;

    localparam int S   = 8;
    localparam int LOG = 16384;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       record_start = 1'b0;
    logic       record_stop  = 1'b0;
    logic [9:0] keys = '0;
    logic       recording;
    logic       done;
`ifdef RECORDER_METRONOME_EN
    logic       click;
`endif

    sequence_recorder_if #(.NOTES(10), .ADDR_W(6)) ram ();

    sequence_recorder #(.STEP_CYCLES(S), .NOTES(10), .ADDR_W(6)) dut (
        .clock        (clock),
        .reset        (reset),
        .record_start (record_start),
        .record_stop  (record_stop),
        .keys         (keys),
`ifdef RECORDER_METRONOME_EN
        .click        (click),
`endif
        .recording    (recording),
        .done         (done),
        .ram          (ram)
    );

    always #5 clock = ~clock;

    int         n_cmp = 0;
    int         n_err = 0;
    int         edge_n = 0;
    logic [9:0] key_at [LOG];
    logic       rec_at [LOG];
    logic       clk_at [LOG];
    int         w_edge[$], w_addr[$], w_data[$], done_q[$];
    logic [9:0] rk = '0;
    int         rk_hold = 0;

    always @(posedge clock) edge_n <= edge_n + 1;

    // Monitor: everything observed is tagged with the index of the preceding clock edge.
    always @(negedge clock) begin
        if (ram.ram_wren) begin
            w_edge.push_back(edge_n);
            w_addr.push_back(int'(ram.ram_address));
            w_data.push_back(int'(ram.ram_data));
        end
        if (done) done_q.push_back(edge_n);
        if (edge_n < LOG) begin
            rec_at[edge_n] <= recording;
`ifdef RECORDER_METRONOME_EN
            clk_at[edge_n] <= click;
`else
            clk_at[edge_n] <= 1'b0;
`endif
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Apply inputs for one cycle; e returns the clock edge that samples them.
    task automatic drive(input logic [9:0] k, input logic st, input logic sp, input logic rs, output int e);
        @(negedge clock);
        keys = k; record_start = st; record_stop = sp; reset = rs;
        e = edge_n + 1;
        if (e < LOG) key_at[e] = k;
    endtask

    function automatic logic [9:0] or_keys(input int lo, input int hi);
        logic [9:0] r = '0;
        for (int i = lo; i <= hi; i++) if (i >= 0 && i < LOG) r |= key_at[i];
        return r;
    endfunction

    function automatic logic [9:0] take_keys(input int mode, input int r);
        case (mode)
            1: begin
                if (r >= 0 && r <= S - 3)     return 10'h001;
                if (r >= S && r <= 2 * S - 3) return 10'h200;
                return '0;
            end
            2: begin
                if (r >= 3 * S + 2 && r <= 3 * S + 4) return 10'h020;
                if (r == 5 * S + 3)                   return 10'h080;
                return '0;
            end
            3: return 10'h001;
            default: begin
                if (rk_hold == 0) begin
                    rk      = 10'($urandom) & 10'($urandom) & 10'($urandom);
                    rk_hold = $urandom_range(1, 12);
                end
                rk_hold--;
                return rk;
            end
        endcase
    endfunction

    function automatic int last_write_rel(input int stop_rel);
        if (stop_rel < 0) return 64 * S;
        return stop_rel + 63 - (stop_rel - 1) / S;
    endfunction

    task automatic clear_log();
        w_edge.delete(); w_addr.delete(); w_data.delete(); done_q.delete();
    endtask

    // Reference: step k holds the OR of keys sampled on edges s0+k*S-1 .. write_edge-2.
    task automatic verify_take(input int s0, input int stop_rel);
        int k_stop, rec_end, last, e_exp, bad_rec, bad_clk, q;
        logic [9:0] d_exp;
        logic rec_exp, clk_exp;
        k_stop  = (stop_rel < 0) ? 64 : (stop_rel - 1) / S;
        rec_end = (stop_rel < 0) ? s0 + 64 * S : s0 + stop_rel;
        last    = s0 + last_write_rel(stop_rel);
        check("write_count", w_edge.size(), 64);
        for (int a = 0; a < 64 && a < w_edge.size(); a++) begin
            if (a < k_stop) begin
                e_exp = s0 + (a + 1) * S;
                d_exp = or_keys(s0 + a * S - 1, e_exp - 2);
            end else if (a == k_stop) begin
                e_exp = rec_end;
                d_exp = or_keys(s0 + a * S - 1, rec_end - 2);
            end else begin
                e_exp = rec_end + (a - k_stop);
                d_exp = '0;
            end
            check("write_edge", w_edge[a] - s0, e_exp - s0);
            check("write_addr", w_addr[a], a);
            check("write_data", w_data[a], int'(d_exp));
        end
        check("done_count", done_q.size(), 1);
        if (done_q.size() > 0) check("done_edge", done_q[0] - s0, last + 1 - s0);
        bad_rec = 0; bad_clk = 0;
        for (int e = s0 - 1; e <= last + 2; e++) begin
            q       = e - s0;
            rec_exp = (e >= s0) && (e < rec_end);
            clk_exp = rec_exp && ((q / S) % 4 == 0) && ((q % S) < S / 4);
            if (rec_at[e] !== rec_exp) bad_rec++;
`ifdef RECORDER_METRONOME_EN
            if (clk_at[e] !== clk_exp) bad_clk++;
`else
            if (clk_exp && 1'b0) bad_clk++;
`endif
        end
        check("recording_bad_cycles", bad_rec, 0);
`ifdef RECORDER_METRONOME_EN
        check("click_bad_cycles", bad_clk, 0);
`endif
    endtask

    task automatic run_take(input int mode, input int stop_rel);
        int s0, e, last_rel;
        logic st, sp;
        clear_log();
        last_rel = last_write_rel(stop_rel);
        drive(take_keys(mode, 0), 1'b1, 1'b0, 1'b0, s0);
        for (int r = 1; r <= last_rel + 3; r++) begin
            st = (mode == 0) && (r < last_rel) && ($urandom_range(0, 15) == 0);
            sp = (r == stop_rel) || (mode == 0 && stop_rel > 0 && r > stop_rel && $urandom_range(0, 7) == 0);
            drive(take_keys(mode, r), st, sp, 1'b0, e);
        end
        drive('0, 1'b0, 1'b0, 1'b0, e);
        verify_take(s0, stop_rel);
    endtask

    initial begin
        int e, s0, nz, rec_hi;

        repeat (3) drive('0, 1'b0, 1'b0, 1'b1, e);
        @(negedge clock);
        check("rst_wren", int'(ram.ram_wren), 0);
        check("rst_addr", int'(ram.ram_address), 0);
        check("rst_data", int'(ram.ram_data), 0);
        check("rst_recording", int'(recording), 0);
        check("rst_done", int'(done), 0);
`ifdef RECORDER_METRONOME_EN
        check("rst_click", int'(click), 0);
`endif

        // Basic capture
        run_take(1, -1);
        if (w_data.size() >= 3) begin
            check("basic_a0", w_data[0], 'h001);
            check("basic_a1", w_data[1], 'h200);
            check("basic_a2", w_data[2], 0);
        end

        // Short and single-cycle key pulses
        run_take(2, -1);
        if (w_data.size() >= 7) begin
            check("pulse_a3", w_data[3], 'h020);
            check("pulse_a5", w_data[5], 'h080);
            check("pulse_a6", w_data[6], 0);
        end

        // Early stop in step 10
        run_take(3, 10 * S + 4);
        nz = 0;
        for (int i = 0; i < w_addr.size(); i++) if (w_addr[i] > 10 && w_data[i] == 0) nz++;
        check("stop_zero_writes", nz, 53);
        if (w_data.size() > 10) check("stop_a10", w_data[10], 'h001);

        // Start and stop together in IDLE
        clear_log();
        drive(10'h3ff, 1'b1, 1'b1, 1'b0, s0);
        for (int r = 0; r < 3 * S; r++) drive(10'($urandom), 1'b0, 1'b0, 1'b0, e);
        drive('0, 1'b0, 1'b0, 1'b0, e);
        rec_hi = 0;
        for (int i = s0; i <= e - 1; i++) if (rec_at[i] !== 1'b0) rec_hi++;
        check("prio_writes", w_edge.size(), 0);
        check("prio_recording", rec_hi, 0);

        // Reset during step 20
        clear_log();
        drive(take_keys(0, 0), 1'b1, 1'b0, 1'b0, s0);
        for (int r = 1; r <= 20 * S + 3; r++) drive(take_keys(0, r), 1'b0, 1'b0, r == 20 * S + 3, e);
        @(negedge clock);
        check("midrst_wren", int'(ram.ram_wren), 0);
        check("midrst_recording", int'(recording), 0);
        check("midrst_addr", int'(ram.ram_address), 0);
        check("midrst_done", int'(done), 0);
        repeat (2) drive('0, 1'b0, 1'b0, 1'b0, e);
        check("midrst_writes", w_edge.size(), 20);
        if (w_addr.size() >= 20) check("midrst_last_addr", w_addr[19], 19);
        check("midrst_done_count", done_q.size(), 0);

        // Randomised takes, including stop on a step boundary and in the last step
        run_take(0, -1);
        run_take(0, $urandom_range(1, 64 * S));
        run_take(0, 5 * S);
        run_take(0, 63 * S + 3);
        run_take(0, 64 * S);
        run_take(0, $urandom_range(1, 8));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sequence_recorder.md
# sequence_recorder

Captures live key presses into the 64-entry, 10-bit note sequence RAM that the playback stage later reads. Sits directly upstream of playback, driving the RAM write port (address, data, write enable). Time is quantised into fixed-length steps: every key held at any point during a step is written as a set bit in that step's RAM word. Unused steps after an early stop are zero-filled so looped playback stays clean.

## Interface
- STEP_CYCLES, 6250000, clock cycles per step (8 steps/s at 50 MHz); legal range ≥ 4
- NOTES, 10, number of note keys / RAM word width
- ADDR_W, 6, RAM address width; depth = 2**ADDR_W
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- record_start  in  1  one-cycle pulse; begins a take at address 0
- record_stop  in  1  one-cycle pulse; ends take early
- keys  in  NOTES  raw asynchronous key levels, 1 = pressed
- ram_address  out  ADDR_W  RAM write address
- ram_data  out  NOTES  RAM write data
- ram_wren  out  1  RAM write enable, one-cycle pulses
- recording  out  1  high in RECORD state
- done  out  1  one-cycle pulse when take (including zero fill) completes

## Operation
- keys pass a 2-flop synchroniser per bit; all logic uses synchronised keys.
- States: IDLE, RECORD, FILL.
- IDLE: outputs quiet. record_start (with record_stop low) → RECORD; address = 0, step counter = STEP_CYCLES-1, accumulator = 0.
- RECORD: accumulator |= synced keys every cycle. Counter decrements; at 0 it writes accumulator OR current synced keys to the current address, clears accumulator, reloads counter, increments address.
  - Write at address DEPTH-1 → IDLE, done pulses.
  - record_stop: writes the partial accumulator (OR current keys) to the current address the same cycle. If that address is DEPTH-1 → IDLE with done; otherwise → FILL at address+1.
  - record_start is ignored in RECORD.
- FILL: writes 0 every cycle, incrementing the address. After the write to DEPTH-1 → IDLE, done pulses. start and stop are ignored.
- record_start and record_stop high together in IDLE: stop wins, so nothing happens.
- Address arithmetic is ADDR_W bits. It never wraps during a take because termination at DEPTH-1 is explicit.

## Timing
- All outputs are registered. Reset values: ram_address 0, ram_data 0, ram_wren 0, recording 0, done 0. The synchroniser, accumulator and counter also clear.
- A key edge reaches the accumulator 2 cycles after the edge. A key must be held ≥ 3 cycles to be guaranteed captured.
- Step write: ram_wren, ram_address and ram_data are valid together for exactly one cycle, on the cycle after the counter reads 0. The first write of a take occurs STEP_CYCLES+1 cycles after the start pulse.
- recording rises on the cycle after record_start. It falls in the same cycle as the final RECORD write or the stop write.
- FILL writes back-to-back, one per cycle, with no gap after the stop write.
- done pulses on the cycle after the last write.
- reset mid-take → IDLE at the next edge with ram_wren 0. Partially written RAM contents are left as they are.

## Configuration
- RECORDER_METRONOME_EN defined: adds output port click (1 bit, reset 0). click is high for the first STEP_CYCLES/4 cycles of each RECORD step whose address[1:0] == 0, and is low in IDLE and FILL.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

## Structure
- Shared package recorder_pkg holds:
  - state enum (IDLE, RECORD, FILL)
  - default NOTES, ADDR_W, STEP_CYCLES constants
  - DEPTH derived constant
- One sub-module: key_sync, a parameterised NOTES-wide 2-flop synchroniser.

## Test plan
(All scenarios use STEP_CYCLES=8.)
- Basic capture: start; hold keys=10'h001 during step 0, keys=10'h200 during step 1, none after → writes 001, 200, then 0 to addr 2..63; done once; total writes 64.
- Short key pulse: 3-cycle pulse of key 5 mid-step 3 → addr 3 data 10'h020. A 1-cycle pulse must not cause X or a stuck bit.
- Early stop: stop at cycle 4 of step 10 with key 0 held → addr 10 = 10'h001, then 53 consecutive zero writes (addr 11..63), done on the cycle after addr 63.
- Priority: start and stop together in IDLE → no transition, no writes. Start pulses during RECORD → address sequence unaffected.
- Reset: reset during step 20 → next cycle ram_wren=0, recording=0, address=0. A new start records from addr 0.
- Metronome (with RECORDER_METRONOME_EN): click is high for cycles 0-1 of steps 0, 4, 8, … and low elsewhere and in FILL.
